vga_timing_controller: RTL and testbench

Display-side end of the VGA pixel path. It generates the `h_count`/`v_count` raster coordinates that the sprite blocks consume and accepts their `RGB`/`visible` answers. It produces registered 8-bit R/G/B, active-low `hsync`/`vsync`, `blank_n` and the DAC pixel clock for the board's video DAC. Default timing is 640x480@60 Hz from a 50 MHz `FPGA_Clock`, with a clock-enable divider of 2.

---
 rtl/vga_timing_controller_if.sv | 28 ++
 rtl/vga_timing_controller.sv | 116 +++++++++++
 tb/tb_vga_timing_controller.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_controller_if.sv
// Raster/sprite/DAC signal bundle between the VGA timing controller (master)
// and the sprite pipeline plus video DAC (slave).
interface vga_timing_controller_if;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic [23:0] sprite_RGB;
  logic        sprite_visible;
  logic [7:0]  vga_R;
  logic [7:0]  vga_G;
  logic [7:0]  vga_B;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic        vga_clk;
  logic        frame_start;

  modport master (
    output h_count, v_count,
    output vga_R, vga_G, vga_B, hsync, vsync, blank_n, vga_clk, frame_start,
    input  sprite_RGB, sprite_visible
  );

  modport slave (
    input  h_count, v_count,
    input  vga_R, vga_G, vga_B, hsync, vsync, blank_n, vga_clk, frame_start,
    output sprite_RGB, sprite_visible
  );
endinterface

// File: rtl/vga_timing_controller.sv
// VGA raster generator: clock-enable divider, h/v counters, sync/blank decode
// and a registered colour stage that lags the counters by one pixel.
module vga_timing_controller #(
  parameter int          H_VISIBLE = 640,
  parameter int          H_FRONT   = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FRONT   = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33,
  parameter int          CLK_DIV   = 2,
  parameter logic [23:0] BG_COLOR  = 24'h000000
) (
  input  logic                      FPGA_Clock,
  input  logic                      FPGA_Reset,
  vga_timing_controller_if.master   vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  // Sync windows as [begin, end) so the compare stays a simple range check.
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]    h_cnt_q, h_cnt_d;
  logic [9:0]    v_cnt_q, v_cnt_d;
  logic          hsync_q, vsync_q, blank_q;
  logic [23:0]   rgb_q;
  logic          vga_clk_q, vga_clk_d;
  logic          frame_q;

  logic          pix_en;
  logic          h_last, v_last;
  logic          active, hs_raw, vs_raw;
  logic [23:0]   pix_rgb;

  assign pix_en = (div_cnt_q == DIV_LAST);
  assign h_last = (h_cnt_q == H_LAST);
  assign v_last = (v_cnt_q == V_LAST);

  always_comb begin
    div_cnt_d = pix_en ? '0 : div_cnt_q + 1'b1;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (pix_en) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
    // DAC clock rises mid-pixel so it samples between colour updates.
    vga_clk_d = (div_cnt_d >= DIV_HALF);
  end

  always_comb begin
    active  = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hs_raw  = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vs_raw  = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    pix_rgb = 24'h0;
    if (active) pix_rgb = vga.sprite_visible ? vga.sprite_RGB : BG_COLOR;
  end

  always_ff @(posedge FPGA_Clock or posedge FPGA_Reset) begin
    if (FPGA_Reset) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_q   <= 1'b0;
      rgb_q     <= 24'h0;
      vga_clk_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      vga_clk_q <= vga_clk_d;
      frame_q   <= pix_en && h_last && v_last;
      // Output stage samples the pre-increment counters: one pixel of lag.
      if (pix_en) begin
        hsync_q <= hs_raw;
        vsync_q <= vs_raw;
        blank_q <= active;
        rgb_q   <= pix_rgb;
      end
    end
  end

  assign vga.h_count     = h_cnt_q;
  assign vga.v_count     = v_cnt_q;
  assign vga.vga_R       = rgb_q[23:16];
  assign vga.vga_G       = rgb_q[15:8];
  assign vga.vga_B       = rgb_q[7:0];
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.blank_n     = blank_q;
  assign vga.vga_clk     = vga_clk_q;
  assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller on a reduced raster (14x8 pixels, 4 clocks
// per pixel); a position-from-edge-count model is compared every cycle.
module tb_vga_timing_controller;
  localparam int CD = 4;
  localparam int HV = 8, HF = 2, HS = 2, HB = 2;
  localparam int VV = 2, VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam logic [23:0] BG = 24'h123456;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   e = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  vga_timing_controller_if bus();

  vga_timing_controller #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(CD), .BG_COLOR(BG)
  ) dut (
    .FPGA_Clock(clk),
    .FPGA_Reset(rst),
    .vga(bus)
  );

  function automatic logic sp_vis(input int h, input int v);
    return (h == 2 && v == 1) || (h % 3 == 1) || (h >= HV) || (v >= VV);
  endfunction

  function automatic logic [23:0] sp_rgb(input int h, input int v);
    if (h == 2 && v == 1) return 24'hFF8000;
    return {8'(h * 16), 8'(v * 32), 8'h5A};
  endfunction

  assign bus.sprite_visible = sp_vis(int'(bus.h_count), int'(bus.v_count));
  assign bus.sprite_RGB     = sp_rgb(int'(bus.h_count), int'(bus.v_count));

  // Rising clock edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) e <= 0;
    else     e <= e + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, e);
    end
  endtask

  function automatic logic [23:0] rgb_out();
    return {bus.vga_R, bus.vga_G, bus.vga_B};
  endfunction

  // Position is pixel index floor(e/CD) in the frame; outputs show the previous pixel.
  task automatic model_cmp();
    int p, cur, q, qh, qv;
    logic act, ehs, evs;
    logic [23:0] ergb;
    p   = e / CD;
    cur = p % FT;
    chk("h_count", 32'(bus.h_count), cur % HT);
    chk("v_count", 32'(bus.v_count), cur / HT);
    chk("vga_clk", 32'(bus.vga_clk), 32'((e % CD) >= CD / 2));
    chk("frame_start", 32'(bus.frame_start), 32'(e % CD == 0 && p > 0 && p % FT == 0));
    if (p == 0) begin
      act = 1'b0; ehs = 1'b1; evs = 1'b1; ergb = 24'h0;
    end else begin
      q    = (p - 1) % FT;
      qh   = q % HT;
      qv   = q / HT;
      act  = (qh < HV) && (qv < VV);
      ehs  = !(qh >= HV + HF && qh < HV + HF + HS);
      evs  = !(qv >= VV + VF && qv < VV + VF + VS);
      ergb = act ? (sp_vis(qh, qv) ? sp_rgb(qh, qv) : BG) : 24'h0;
    end
    chk("hsync", 32'(bus.hsync), 32'(ehs));
    chk("vsync", 32'(bus.vsync), 32'(evs));
    chk("blank_n", 32'(bus.blank_n), 32'(act));
    chk("rgb", 32'(rgb_out()), 32'(ergb));
  endtask

  task automatic tick();
    @(negedge clk);
    if (!rst) model_cmp();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " h_count"}, 32'(bus.h_count), 0);
    chk({tag, " v_count"}, 32'(bus.v_count), 0);
    chk({tag, " hsync"}, 32'(bus.hsync), 1);
    chk({tag, " vsync"}, 32'(bus.vsync), 1);
    chk({tag, " blank_n"}, 32'(bus.blank_n), 0);
    chk({tag, " rgb"}, 32'(rgb_out()), 0);
    chk({tag, " vga_clk"}, 32'(bus.vga_clk), 0);
    chk({tag, " frame_start"}, 32'(bus.frame_start), 0);
  endtask

  task automatic wait_hv(input int h, input int v, input string nm);
    int n = 0;
    while (!(int'(bus.h_count) == h && int'(bus.v_count) == v) && n < 3000) begin
      tick();
      n++;
    end
    chk({nm, " reached"}, 32'(n < 3000), 1);
  endtask

  // Pulse-width / period monitor, in clocks.
  int   cyc, hs_fall_t, hs_low_w, hs_period, hs_falls;
  int   vs_fall_t, vs_low_w, bl_rise_t, bl_high_w;
  int   fs_t, fs_period, fs_cnt, fs_run, fs_width;
  logic prev_hs, prev_vs, prev_bl, prev_fs;

  always @(negedge clk) begin
    if (rst) begin
      cyc <= 0; hs_fall_t <= 0; hs_low_w <= 0; hs_period <= 0; hs_falls <= 0;
      vs_fall_t <= 0; vs_low_w <= 0; bl_rise_t <= 0; bl_high_w <= 0;
      fs_t <= 0; fs_period <= 0; fs_cnt <= 0; fs_run <= 0; fs_width <= 0;
      prev_hs <= 1'b1; prev_vs <= 1'b1; prev_bl <= 1'b0; prev_fs <= 1'b0;
    end else begin
      cyc     <= cyc + 1;
      prev_hs <= bus.hsync;
      prev_vs <= bus.vsync;
      prev_bl <= bus.blank_n;
      prev_fs <= bus.frame_start;
      if (prev_hs && !bus.hsync) begin
        if (hs_falls > 0) hs_period <= cyc - hs_fall_t;
        hs_fall_t <= cyc;
        hs_falls  <= hs_falls + 1;
      end
      if (!prev_hs && bus.hsync) hs_low_w <= cyc - hs_fall_t;
      if (prev_vs && !bus.vsync) vs_fall_t <= cyc;
      if (!prev_vs && bus.vsync) vs_low_w <= cyc - vs_fall_t;
      if (!prev_bl && bus.blank_n) bl_rise_t <= cyc;
      if (prev_bl && !bus.blank_n) bl_high_w <= cyc - bl_rise_t;
      if (bus.frame_start) fs_run <= fs_run + 1;
      else if (prev_fs) begin
        fs_width <= fs_run;
        fs_run   <= 0;
      end
      if (bus.frame_start && !prev_fs) begin
        if (fs_cnt > 0) fs_period <= cyc - fs_t;
        fs_t   <= cyc;
        fs_cnt <= fs_cnt + 1;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;

    // First pixel enable lands on edge CD.
    tick(); chk("e1 h_count", 32'(bus.h_count), 0); chk("e1 vga_clk", 32'(bus.vga_clk), 0);
    tick(); chk("e2 vga_clk", 32'(bus.vga_clk), 1);
    tick(); chk("e3 h_count", 32'(bus.h_count), 0); chk("e3 vga_clk", 32'(bus.vga_clk), 1);
    tick();
    chk("e4 h_count", 32'(bus.h_count), 1);
    chk("e4 vga_clk", 32'(bus.vga_clk), 0);
    chk("e4 blank_n", 32'(bus.blank_n), 1);
    chk("e4 bg rgb", 32'(rgb_out()), 32'h123456);

    wait_hv(2, 0, "px(1,0)");
    chk("sprite rgb (1,0)", 32'(rgb_out()), 32'h10005A);
    wait_hv(3, 1, "px(2,1)");
    chk("sprite R", 32'(bus.vga_R), 32'hFF);
    chk("sprite G", 32'(bus.vga_G), 32'h80);
    chk("sprite B", 32'(bus.vga_B), 32'h00);
    wait_hv(11, 1, "px(10,1)");
    chk("sync hsync", 32'(bus.hsync), 0);
    chk("sync blank_n", 32'(bus.blank_n), 0);
    chk("sync rgb ignores sprite", 32'(rgb_out()), 0);
    wait_hv(0, 4, "px(13,3)");
    chk("vsync before", 32'(bus.vsync), 1);
    wait_hv(1, 4, "px(0,4)");
    chk("vsync start", 32'(bus.vsync), 0);

    // Asynchronous reset while both syncs are low.
    wait_hv(11, 5, "px(10,5)");
    chk("pre-reset hsync", 32'(bus.hsync), 0);
    chk("pre-reset vsync", 32'(bus.vsync), 0);
    #3 rst = 1'b1;
    #1 chk_reset("mid");
    tick();
    tick();
    chk_reset("mid hold");
    rst = 1'b0;

    n = 0;
    while (!bus.frame_start && n < 1000) begin
      tick();
      n++;
    end
    chk("frame_start seen", 32'(n < 1000), 1);
    chk("frame_start edge", 32'(e), 448);
    chk("frame_start h", 32'(bus.h_count), 0);
    chk("frame_start v", 32'(bus.v_count), 0);

    repeat (700) tick();
    chk("hsync low clocks", 32'(hs_low_w), 8);
    chk("line period clocks", 32'(hs_period), 56);
    chk("vsync low clocks", 32'(vs_low_w), 112);
    chk("blank_n high clocks", 32'(bl_high_w), 32);
    chk("frame pulses", 32'(fs_cnt >= 2), 1);
    chk("frame_start width", 32'(fs_width), 1);
    chk("frame period clocks", 32'(fs_period), 448);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
